// File: rtl/finv_pkg.sv
// Shared definitions for the finv arbiter: default sizing and the tag that
// travels alongside each operation through the shared finv pipeline.
package finv_pkg;

  localparam int unsigned FINV_LAT_DEF = 4;  // finv pipeline latency (edges)
  localparam int unsigned NREQ_DEF     = 2;  // requesters sharing one finv
  localparam int unsigned MAX_OUT_DEF  = 4;  // in-flight ops per requester
  localparam int unsigned TAG_ID_W     = 8;  // room for up to 256 requesters

  // Operation tag: valid marks a real operation, id names its requester.
  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } finv_tag_t;

endpackage

// File: rtl/finv_tag_pipe.sv
// Fixed-depth shift register of operation tags with synchronous clear.
// Ports:
//   clk    clock, rising edge
//   clr_i  synchronous clear of every stage (active-high)
//   tag_i  tag entering stage 0
//   tag_o  tag leaving the last stage
module finv_tag_pipe
  import finv_pkg::*;
#(
  parameter int unsigned DEPTH = FINV_LAT_DEF
) (
  input  logic      clk,
  input  logic      clr_i,
  input  finv_tag_t tag_i,
  output finv_tag_t tag_o
);

  finv_tag_t stage_q [DEPTH];

  // Shift one stage per edge; clear drops every tag in flight.
  always_ff @(posedge clk) begin
    if (clr_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= tag_i;
      for (int unsigned i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/finv_arb.sv
// Round-robin arbiter sharing one pipelined finv unit among NREQ requesters,
// with a per-requester credit limit and tag-based response routing.
// Ports:
//   clk         clock, rising edge
//   rst         synchronous reset, active-high
//   req_valid   per-requester operation request
//   req_x       per-requester single-precision operand
//   req_ready   per-requester accept (one-hot grant, combinational)
//   finv_x      registered operand to the shared finv
//   finv_y      result from the shared finv
//   resp_valid  one-hot completion pulse
//   resp_y      result, meaningful while resp_valid is non-zero
module finv_arb
  import finv_pkg::*;
#(
  parameter int unsigned NREQ     = NREQ_DEF,
  parameter int unsigned FINV_LAT = FINV_LAT_DEF,
  parameter int unsigned MAX_OUT  = MAX_OUT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0][31:0] req_x,
  output logic [NREQ-1:0]      req_ready,
  output logic [31:0]          finv_x,
  input  logic [31:0]          finv_y,
  output logic [NREQ-1:0]      resp_valid,
  output logic [31:0]          resp_y
);

  localparam int unsigned IDW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

  logic [IDW-1:0]             rr_q, rr_d;
  logic [IDW-1:0]             grant_id;
  logic                       grant_vld;
  logic [NREQ-1:0]            eligible;
  logic [NREQ-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]                finv_x_q;
  finv_tag_t                  tag_d, tag_q, tag_out;
  int unsigned                idx;

  // Response routing: the tag leaving the pipe lines up with finv_y.
  assign resp_valid = (tag_out.valid && !rst) ? (NREQ'(1) << tag_out.id) : '0;
  assign resp_y     = finv_y;
  assign finv_x     = finv_x_q;

  // A requester at its credit limit regains eligibility in its retire cycle.
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      eligible[IDW'(i)] = req_valid[IDW'(i)] && !rst &&
                          ((cnt_q[IDW'(i)] < CNT_W'(MAX_OUT)) || resp_valid[IDW'(i)]);
    end
  end

  // Round-robin pick: first eligible requester at or after rr_q.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    idx       = 0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      idx = (32'(rr_q) + off) % NREQ;
      if (!grant_vld && eligible[IDW'(idx)]) begin
        grant_vld = 1'b1;
        grant_id  = IDW'(idx);
      end
    end
  end

  assign req_ready = grant_vld ? (NREQ'(1) << grant_id) : '0;

  // Pointer and credit next-state; accept plus retire on one requester cancels.
  always_comb begin
    rr_d  = rr_q;
    cnt_d = cnt_q;
    tag_d = '{valid: grant_vld, id: TAG_ID_W'(grant_id)};
    if (grant_vld) begin
      rr_d = (32'(grant_id) == NREQ - 1) ? '0 : grant_id + IDW'(1);
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (req_ready[IDW'(i)] && !resp_valid[IDW'(i)]) begin
        cnt_d[IDW'(i)] = cnt_q[IDW'(i)] + CNT_W'(1);
      end else if (!req_ready[IDW'(i)] && resp_valid[IDW'(i)]) begin
        cnt_d[IDW'(i)] = cnt_q[IDW'(i)] - CNT_W'(1);
      end
    end
  end

  // State registers; tag_q shadows finv_x so the pipe matches finv's depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q     <= '0;
      cnt_q    <= '0;
      finv_x_q <= '0;
      tag_q    <= '0;
    end else begin
      rr_q  <= rr_d;
      cnt_q <= cnt_d;
      tag_q <= tag_d;
      if (grant_vld) finv_x_q <= req_x[grant_id];
    end
  end

  finv_tag_pipe #(
    .DEPTH (FINV_LAT)
  ) u_tag_pipe (
    .clk   (clk),
    .clr_i (rst),
    .tag_i (tag_q),
    .tag_o (tag_out)
  );

endmodule

// File: tb/tb_finv_arb.sv
// Self-checking bench for finv_arb: emulates the shared finv pipeline and
// checks the DUT every cycle against a cycle-indexed scoreboard model.
module tb_finv_arb;
  import finv_pkg::*;

  localparam int NREQ    = 2;
  localparam int LAT     = FINV_LAT_DEF;
  localparam int MAX_OUT = MAX_OUT_DEF;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0][31:0] req_x;
  logic [NREQ-1:0]       req_ready;
  logic [31:0]           finv_x;
  logic [31:0]           finv_y;
  logic [NREQ-1:0]       resp_valid;
  logic [31:0]           resp_y;

  int n_vec = 0;
  int n_err = 0;

  finv_arb #(
    .NREQ     (NREQ),
    .FINV_LAT (LAT),
    .MAX_OUT  (MAX_OUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_x      (req_x),
    .req_ready  (req_ready),
    .finv_x     (finv_x),
    .finv_y     (finv_y),
    .resp_valid (resp_valid),
    .resp_y     (resp_y)
  );

  always #5 clk = ~clk;

  // Reciprocal of a normal single (mantissa truncated); non-normal inputs map
  // to a recognisable pattern so pass-through of odd values is exercised.
  function automatic logic [31:0] finv_ref(input logic [31:0] x);
    logic [63:0] d;
    real         r;
    if (x[30:23] == 8'd0 || x[30:23] == 8'hFF) return x ^ 32'h0040_0001;
    d = {x[31], 11'(32'(x[30:23]) + 32'd896), x[22:0], 29'd0};
    r = 1.0 / $bitstoreal(d);
    d = $realtobits(r);
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  // Shared finv emulation: LAT registers after finv_x.
  logic [31:0] fpipe [LAT];
  always @(posedge clk) begin
    fpipe[0] <= finv_ref(finv_x);
    for (int i = 1; i < LAT; i++) fpipe[i] <= fpipe[i-1];
  end
  assign finv_y = fpipe[LAT-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard model: credits, rr pointer and in-flight ops keyed by due cycle.
  int          m_cnt [NREQ];
  int          m_rr;
  logic [31:0] m_fx;
  int          m_cyc = 0;
  int          due_q [$];
  int          id_q  [$];
  logic [31:0] x_q   [$];

  always @(negedge clk) begin
    logic [NREQ-1:0] exp_rdy;
    logic [NREQ-1:0] exp_rsp;
    logic [31:0]     exp_y;
    int              rid;
    int              g;
    int              ii;
    m_cyc++;
    if (rst) begin
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_resp", 32'(resp_valid), 32'd0);
      due_q.delete(); id_q.delete(); x_q.delete();
      for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
      m_rr = 0;
      m_fx = 32'd0;
    end else begin
      exp_rsp = '0;
      exp_y   = 32'd0;
      rid     = -1;
      if (due_q.size() > 0 && due_q[0] == m_cyc) begin
        rid          = id_q[0];
        exp_rsp[rid] = 1'b1;
        exp_y        = finv_ref(x_q[0]);
        void'(due_q.pop_front());
        void'(id_q.pop_front());
        void'(x_q.pop_front());
      end
      g = -1;
      for (int o = 0; o < NREQ; o++) begin
        ii = (m_rr + o) % NREQ;
        if (g < 0 && req_valid[ii] && (m_cnt[ii] < MAX_OUT || rid == ii)) g = ii;
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("ready", 32'(req_ready), 32'(exp_rdy));
      chk("resp_valid", 32'(resp_valid), 32'(exp_rsp));
      chk("finv_x", finv_x, m_fx);
      if (exp_rsp != '0) chk("resp_y", resp_y, exp_y);
      if (rid >= 0) m_cnt[rid]--;
      if (g >= 0) begin
        m_cnt[g]++;
        m_rr = (g + 1) % NREQ;
        m_fx = req_x[g];
        due_q.push_back(m_cyc + LAT + 1);
        id_q.push_back(g);
        x_q.push_back(req_x[g]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    req_valid = '0;
    rst       = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_x();
    case ($urandom_range(0, 31))
      0:       return 32'h0000_0000;
      1:       return 32'h7F80_0000;
      2:       return 32'h7FC0_0001;
      3:       return {9'd0, 23'($urandom)};
      default: return {1'($urandom), 8'd127, 23'($urandom)};
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_x     = '0;

    // Pin the reference reciprocal itself.
    chk("ref_half", finv_ref(32'h4000_0000), 32'h3F00_0000);
    chk("ref_one", finv_ref(32'h3F80_0000), 32'h3F80_0000);
    chk("ref_quarter", finv_ref(32'h4080_0000), 32'h3E80_0000);
    chk("ref_1p5", finv_ref(32'h3FC0_0000), 32'h3F2A_AAAA);

    do_reset(2);

    // Single operation latency.
    req_x[0]  = 32'h4000_0000;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    repeat (LAT - 1) tick();
    @(negedge clk);
    chk("s1_early", 32'(resp_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("s1_valid", 32'(resp_valid), 32'd1);
    chk("s1_y", resp_y, 32'h3F00_0000);
    repeat (3) tick();

    // Contention: alternating grants and results.
    do_reset(1);
    req_x[0]  = 32'h3F80_0000;
    req_x[1]  = 32'h4080_0000;
    req_valid = 2'b11;
    for (int c = 0; c < LAT + 5; c++) begin
      @(negedge clk);
      if (c < 4) chk("s2_grant", 32'(req_ready), (c % 2 == 0) ? 32'd1 : 32'd2);
      if (c >= LAT + 1) begin
        chk("s2_resp", 32'(resp_valid), ((c - LAT - 1) % 2 == 0) ? 32'd1 : 32'd2);
        chk("s2_y", resp_y, ((c - LAT - 1) % 2 == 0) ? 32'h3F80_0000 : 32'h3E80_0000);
      end
      tick();
    end
    req_valid = 2'b00;
    repeat (LAT + 6) tick();

    // Credit limit on requester 1, then resume in the retire cycle.
    do_reset(1);
    req_valid = 2'b10;
    for (int c = 0; c < 6; c++) begin
      req_x[1] = rand_x();
      @(negedge clk);
      chk("s3_ready", 32'(req_ready[1]), (c == 4) ? 32'd0 : 32'd1);
      if (c == 5) chk("s3_retire", 32'(resp_valid[1]), 32'd1);
      tick();
    end
    req_valid = 2'b00;
    repeat (LAT + 6) tick();

    // Reset with operations in flight.
    do_reset(1);
    req_valid = 2'b11;
    repeat (3) tick();
    req_valid = 2'b00;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < LAT + 3; c++) begin
      @(negedge clk);
      chk("s4_quiet", 32'(resp_valid), 32'd0);
      tick();
    end
    req_valid = 2'b11;
    @(negedge clk);
    chk("s4_first", 32'(req_ready), 32'd1);
    tick();
    req_valid = 2'b00;
    repeat (LAT + 6) tick();

    // Random mix: operands near exponent 127 plus special values.
    for (int n = 0; n < 20000; n++) begin
      rst       = ($urandom_range(0, 999) == 0);
      req_valid = 2'($urandom);
      for (int i = 0; i < NREQ; i++) req_x[i] = rand_x();
      tick();
    end
    rst       = 1'b0;
    req_valid = 2'b00;
    repeat (LAT + 6) tick();
    @(negedge clk);
    chk("drain_empty", 32'(due_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
